// File: rtl/gray_to_binary_sync_if.sv
// ---------------------------------------------------------------------------
// gray_to_binary_sync_if : Gray input / decoded-output bundle for the sync
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gray_to_binary_sync_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_gray;
  logic             err_clr;
  logic [WIDTH-1:0] out_binary;
  logic             out_valid;
  logic             out_changed;
  logic [WIDTH-1:0] out_delta;
  logic             err_pulse;
  logic             err_sticky;

  modport master (
    output in_gray, err_clr,
    input  out_binary, out_valid, out_changed, out_delta, err_pulse, err_sticky
  );

  modport slave (
    input  in_gray, err_clr,
    output out_binary, out_valid, out_changed, out_delta, err_pulse, err_sticky
  );
endinterface

`default_nettype wire

// File: rtl/gray_to_binary_sync.sv
// ---------------------------------------------------------------------------
// gray_to_binary_sync : synchronizes a Gray value, decodes it, flags steps/errors
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gray_to_binary_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  gray_to_binary_sync_if.slave  bus
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] C_FILL_LAST = CNT_W'(SYNC_STAGES);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_fill_cnt;
  logic [CNT_W-1:0] w_fill_cnt_next;
  logic             w_run;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_binary;
  logic [WIDTH-1:0] r_delta;
  logic             r_changed;
  logic             r_err_pulse;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] w_bin_new;
  logic [WIDTH-1:0] w_diff;
  logic             w_one_bit;
  logic             w_multi_bit;

  // Pure capture chain; no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= bus.in_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_gray = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_bin_new[WIDTH-1] = w_gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_bin_new[i] = w_bin_new[i+1] ^ w_gray[i];
    end
  end

  assign w_diff      = w_gray ^ r_prev;
  assign w_multi_bit = (w_diff & (w_diff - WIDTH'(1))) != '0;
  assign w_one_bit   = (w_diff != '0) && !w_multi_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FILL;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fill_cnt <= w_fill_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_cnt_next = r_fill_cnt;
    w_run           = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_fill_cnt_next = r_fill_cnt + CNT_W'(1);
        if (r_fill_cnt == C_FILL_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
      end
      default: begin
        w_state_next = ST_FILL;
      end
    endcase
  end

  // r_binary always equals the decode of r_prev, so it serves as the previous binary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev       <= '0;
      r_binary     <= '0;
      r_delta      <= '0;
      r_changed    <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_prev      <= w_gray;
      r_binary    <= w_bin_new;
      r_delta     <= w_run ? (w_bin_new - r_binary) : '0;
      r_changed   <= w_run & w_one_bit;
      r_err_pulse <= w_run & w_multi_bit;
      // A clear never wins against an error being raised or currently shown.
      if ((w_run & w_multi_bit) || r_err_pulse) begin
        r_err_sticky <= 1'b1;
      end else if (bus.err_clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  assign bus.out_binary  = r_binary;
  assign bus.out_valid   = (r_state == ST_RUN);
  assign bus.out_changed = r_changed;
  assign bus.out_delta   = r_delta;
  assign bus.err_pulse   = r_err_pulse;
  assign bus.err_sticky  = r_err_sticky;

endmodule

`default_nettype wire

// File: doc/gray_to_binary_sync.md
Name: gray_to_binary_sync

Overview:
Receive-side partner of the team's binary-to-Gray encoder. Accepts a Gray-coded value driven from another clock domain, synchronizes it, and converts it back to binary. Also reports per-update change, signed step (delta) and illegal multi-bit transitions. Sits at the capture end of any Gray-coded pointer or counter crossing into the local clock domain.

Parameters:
WIDTH, 4, bit width of the Gray input and binary output (minimum 2).
SYNC_STAGES, 2, number of flip-flop synchronizer stages on in_gray (minimum 2).

Ports:
clk  input  1  local clock; all flops are rising-edge.
rst_n  input  1  asynchronous, active-low reset.
in_gray  input  WIDTH  Gray-coded value, asynchronous to clk.
err_clr  input  1  synchronous clear of the sticky error flag.
out_binary  output  WIDTH  decoded binary value of the synchronized input.
out_valid  output  1  high once the pipeline has filled after reset.
out_changed  output  1  one-cycle pulse: the decoded value changed by a legal single-bit Gray step.
out_delta  output  WIDTH  (new binary - previous binary) mod 2^WIDTH; registered with out_binary.
err_pulse  output  1  one-cycle pulse: more than one Gray bit changed between consecutive synchronized samples.
err_sticky  output  1  latched error flag; set by err_pulse, cleared by err_clr.

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizer stages, prev-sample register and fill counter cleared. All outputs 0: out_binary, out_valid, out_changed, out_delta, err_pulse, err_sticky. Takes effect immediately, including mid-operation.
- Synchronizer: in_gray passes through SYNC_STAGES flops. Each synchronizer flop performs no logic other than capture.
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0. Applied to the last synchronizer stage. Result is registered into out_binary.
- Latency: a value stable on in_gray before edge k appears on out_binary after edge k+SYNC_STAGES (SYNC_STAGES+1 clocks total).
- Control FSM, 2 states:
  - FILL: entered on reset. Counts SYNC_STAGES+1 rising edges. out_valid = 0. out_binary still updates. out_changed and err_pulse forced 0. out_delta held 0. On the final count, transition to RUN.
  - RUN: out_valid = 1 and stays 1 until the next reset.
- Previous-sample register: holds the last synchronized Gray value. Updated every cycle in both states.
- Comparison (RUN only), between the synchronized Gray value and the previous sample, by Hamming distance h:
  - h = 0: out_changed = 0, err_pulse = 0, out_delta = 0.
  - h = 1: out_changed = 1 for one cycle, aligned with the out_binary update; out_delta = difference.
  - h >= 2: err_pulse = 1 for one cycle, out_changed = 0. out_binary and out_delta still update to the decoded value and difference.
- The first sample that enters RUN is compared against a prev register already filled with real data. No spurious error is reported after reset.
- Delta arithmetic: WIDTH-bit modulo subtraction. A legal increment gives 1; a legal decrement gives all ones. Wrap from max to 0 gives 1.
- err_sticky: set on any cycle err_pulse is 1. Cleared on a cycle where err_clr = 1 and err_pulse = 0. If err_clr and err_pulse are both 1 in the same cycle, set wins.
- err_clr has no effect on any other output.

Test Plan:
- Reset release with in_gray = 0110: out_valid and out_binary are 0 until edge 3. out_binary = 0100 after edge 3. out_valid = 1 after edge 3. No err_pulse and no out_changed during FILL.
- Drive the Gray sequence for binary 0..15 and then back to 0, one value per 4 clocks: out_binary follows 0..15 and wraps to 0. Each step gives one out_changed pulse with out_delta = 0001, including the 15 -> 0 wrap (gray 1000 -> 0000). err_sticky stays 0.
- In RUN, step in_gray 0011 -> 0001 (binary 2 -> 1): out_changed pulses, out_delta = 1111, out_binary = 0001.
- In RUN, jump in_gray 0000 -> 0011: err_pulse for one cycle, err_sticky = 1, out_changed = 0, out_binary = 0010, out_delta = 0010. Then pulse err_clr: err_sticky = 0. Then assert err_clr in the same cycle as a new illegal jump: err_sticky remains 1.
- Assert rst_n low mid-stream between clock edges: all outputs go to 0 immediately, before the next edge. On release, the FILL sequence repeats with no error reported.
- Hold in_gray constant for 20 clocks in RUN: out_changed = 0, err_pulse = 0, out_delta = 0 on every cycle.
